// File: rtl/av_master_writer_if.sv
// av_master_writer_if: Avalon-MM single-beat write bus between a write initiator and a memory slave
//   master_address     byte address driven by the initiator
//   master_write       write request, held until accepted
//   master_writedata   write data word
//   master_byteenable  byte lanes, all enabled while writing
//   master_waitrequest slave stall; write accepted when low
interface av_master_writer_if #(parameter int DATA_W = 32);
  logic [31:0] master_address;
  logic master_write;
  logic [DATA_W-1:0] master_writedata;
  logic [3:0] master_byteenable;
  logic master_waitrequest;
  modport master(output master_address, master_write, master_writedata, master_byteenable, input master_waitrequest);
  modport slave(input master_address, master_write, master_writedata, master_byteenable, output master_waitrequest);
endinterface

// File: rtl/av_master_writer.sv
// av_master_writer: drains NUM_POINTS FFT result words to memory as single-beat Avalon writes
//   clk, rst      clock, asynchronous active-high reset
//   fft_done      start pulse, honoured only when idle
//   base_address  destination byte address, latched at start
//   rAddress      result-RAM read address
//   rData         result-RAM read data, one cycle after rAddress
//   bus           Avalon-MM write master port
//   busy          job in progress, including the completion cycle
//   xfer_done     one-cycle pulse after the last word is accepted
module av_master_writer #(
  parameter int NUM_POINTS = 256,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic fft_done,
  input  logic [31:0] base_address,
  output logic [ADDR_W-1:0] rAddress,
  input  logic [DATA_W-1:0] rData,
  av_master_writer_if.master bus,
  output logic busy,
  output logic xfer_done
);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, WRITE, DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_POINTS - 1);
  state_t state;
  logic [ADDR_W-1:0] idx;
  logic [31:0] base;
  // rAddress is loaded on entry to FETCH so the RAM output is ready during LOAD
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      base <= '0;
      rAddress <= '0;
      bus.master_address <= '0;
      bus.master_write <= 1'b0;
      bus.master_writedata <= '0;
      bus.master_byteenable <= 4'h0;
      busy <= 1'b0;
      xfer_done <= 1'b0;
    end else begin
      xfer_done <= 1'b0;
      case (state)
        IDLE: if (fft_done) begin
          base <= base_address;
          idx <= '0;
          rAddress <= '0;
          busy <= 1'b1;
          state <= FETCH;
        end
        FETCH: state <= LOAD;
        LOAD: begin
          bus.master_writedata <= rData;
          bus.master_address <= base + (32'(idx) << 2);
          bus.master_write <= 1'b1;
          bus.master_byteenable <= 4'hF;
          state <= WRITE;
        end
        WRITE: if (!bus.master_waitrequest) begin
          bus.master_write <= 1'b0;
          bus.master_byteenable <= 4'h0;
          if (idx == LAST) begin
            xfer_done <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
            rAddress <= idx + 1'b1;
            state <= FETCH;
          end
        end
        DONE: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_av_master_writer.sv
// tb_av_master_writer: randomized self-checking bench for av_master_writer against a job-level model
module tb_av_master_writer;
  localparam int N = 8, AW = 9, DW = 32;
  logic clk = 0, rst = 1, fft_done = 0;
  logic [31:0] base_address = 0;
  logic [AW-1:0] rAddress;
  logic [DW-1:0] rData;
  logic busy, xfer_done;
  logic [DW-1:0] ram [0:(1<<AW)-1];
  int n_checks = 0, n_pass = 0, cyc = 0, t0 = 0;
  int mode = 0, stall_word = 0, stall_len = 0, stall_cnt = 0;
  int n_acc, n_stall, n_wr, busy_cnt, busy_first, busy_last, be_bad;
  logic [31:0] acc_addr[$], acc_data[$], stall_addr[$], stall_data[$];
  logic [3:0] acc_be[$];
  int done_cyc[$];

  av_master_writer_if #(.DATA_W(DW)) bus();
  av_master_writer #(.NUM_POINTS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .fft_done(fft_done), .base_address(base_address),
    .rAddress(rAddress), .rData(rData), .bus(bus.master), .busy(busy), .xfer_done(xfer_done));

  always #5 clk = ~clk;
  always @(posedge clk) rData <= ram[rAddress];
  always @(posedge clk) cyc <= cyc + 1;

  // slave side: drives waitrequest and records what the bus did each cycle
  initial begin
    bus.master_waitrequest = 1'b0;
    forever begin
      @(negedge clk);
      if (mode == 1) begin
        bus.master_waitrequest = bus.master_write && n_acc == stall_word && stall_cnt < stall_len;
        if (bus.master_waitrequest) stall_cnt++;
      end else bus.master_waitrequest = (mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (bus.master_write) begin
        n_wr++;
        if (bus.master_waitrequest) begin
          n_stall++;
          stall_addr.push_back(bus.master_address);
          stall_data.push_back(bus.master_writedata);
        end else begin
          n_acc++;
          acc_addr.push_back(bus.master_address);
          acc_data.push_back(bus.master_writedata);
          acc_be.push_back(bus.master_byteenable);
        end
      end else if (bus.master_byteenable != 4'h0) be_bad++;
      if (xfer_done) done_cyc.push_back(cyc);
      if (busy) begin
        busy_cnt++;
        busy_last = cyc;
        if (busy_first < 0) busy_first = cyc;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_mon();
    n_acc = 0; n_stall = 0; n_wr = 0; busy_cnt = 0; busy_first = -1; busy_last = -1; be_bad = 0; stall_cnt = 0;
    acc_addr.delete(); acc_data.delete(); acc_be.delete(); stall_addr.delete(); stall_data.delete(); done_cyc.delete();
  endtask

  task automatic start_job(input logic [31:0] b);
    @(posedge clk);
    clear_mon();
    @(negedge clk); #1;
    base_address = b;
    fft_done = 1;
    t0 = cyc;
    @(negedge clk); #1;
    fft_done = 0;
    base_address = $urandom;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (done_cyc.size() > 0) break;
    end
    repeat (10) @(negedge clk);
    #1;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < N; i++) ram[i] = 32'hA500_0000 + i;
  endtask

  task automatic test_reset();
    bit found = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 0;
    fill_ramp();
    mode = 0;
    start_job($urandom);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (bus.master_write) begin found = 1; break; end
    end
    n_checks++;
    if (!found) $display("FAIL reset_setup: no write seen before reset"); else n_pass++;
    @(posedge clk); #3;
    fft_done = $urandom; base_address = $urandom; rst = 1;
    #1;
    n_checks++;
    if ({bus.master_write, bus.master_address, bus.master_writedata, bus.master_byteenable, rAddress, busy, xfer_done} !== '0)
      $display("FAIL reset_outputs: write=%b addr=%h data=%h be=%h raddr=%h busy=%b done=%b expected all zero",
               bus.master_write, bus.master_address, bus.master_writedata, bus.master_byteenable, rAddress, busy, xfer_done);
    else n_pass++;
    @(negedge clk); rst = 0; fft_done = 0;
    @(posedge clk); clear_mon();
    repeat (20) @(negedge clk);
    #1;
    n_checks++;
    if (n_wr !== 0 || busy_cnt !== 0) $display("FAIL reset_idle: writes=%0d busy_cycles=%0d expected 0 and 0", n_wr, busy_cnt);
    else n_pass++;
  endtask

  task automatic test_nominal();
    fill_ramp();
    mode = 0;
    start_job(32'h0000_1000);
    wait_done();
    n_checks++;
    if (n_acc !== N) $display("FAIL nom_count: got %0d writes expected %0d", n_acc, N); else n_pass++;
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (i >= acc_addr.size() || acc_addr[i] !== 32'h1000 + 4 * i || acc_data[i] !== ram[i] || acc_be[i] !== 4'hF)
        $display("FAIL nom_word%0d: got addr=%h data=%h be=%h expected addr=%h data=%h be=F", i,
                 i < acc_addr.size() ? acc_addr[i] : 'x, i < acc_data.size() ? acc_data[i] : 'x,
                 i < acc_be.size() ? acc_be[i] : 'x, 32'h1000 + 4 * i, ram[i]);
      else n_pass++;
    end
    n_checks++;
    if (done_cyc.size() !== 1 || done_cyc[0] - t0 !== 3 * N + 1)
      $display("FAIL nom_done: got %0d pulses first at %0d expected 1 at %0d", done_cyc.size(),
               done_cyc.size() > 0 ? done_cyc[0] - t0 : -1, 3 * N + 1);
    else n_pass++;
    n_checks++;
    if (busy_first - t0 !== 1 || busy_last - t0 !== 3 * N + 1 || busy_cnt !== 3 * N + 1)
      $display("FAIL nom_busy: got first=%0d last=%0d count=%0d expected 1 %0d %0d", busy_first - t0, busy_last - t0,
               busy_cnt, 3 * N + 1, 3 * N + 1);
    else n_pass++;
    n_checks++;
    if (be_bad !== 0) $display("FAIL nom_be_idle: got %0d cycles with byteenable set while idle expected 0", be_bad);
    else n_pass++;
  endtask

  task automatic test_stall();
    fill_ramp();
    mode = 1; stall_word = 2; stall_len = 4;
    start_job(32'h0000_1000);
    wait_done();
    mode = 0;
    n_checks++;
    if (n_acc !== N || n_stall !== 4) $display("FAIL stall_count: got %0d writes %0d stalls expected %0d and 4", n_acc, n_stall, N);
    else n_pass++;
    for (int i = 0; i < stall_addr.size(); i++) begin
      n_checks++;
      if (stall_addr[i] !== 32'h1008 || stall_data[i] !== 32'hA500_0002)
        $display("FAIL stall_hold%0d: got addr=%h data=%h expected 00001008 a5000002", i, stall_addr[i], stall_data[i]);
      else n_pass++;
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (i >= acc_addr.size() || acc_addr[i] !== 32'h1000 + 4 * i || acc_data[i] !== ram[i])
        $display("FAIL stall_word%0d: got addr=%h data=%h expected %h %h", i, i < acc_addr.size() ? acc_addr[i] : 'x,
                 i < acc_data.size() ? acc_data[i] : 'x, 32'h1000 + 4 * i, ram[i]);
      else n_pass++;
    end
    n_checks++;
    if (done_cyc.size() !== 1 || done_cyc[0] - t0 !== 3 * N + 5)
      $display("FAIL stall_done: got %0d pulses first at %0d expected 1 at %0d", done_cyc.size(),
               done_cyc.size() > 0 ? done_cyc[0] - t0 : -1, 3 * N + 5);
    else n_pass++;
  endtask

  task automatic test_start_while_busy();
    bit found = 0;
    fill_ramp();
    mode = 0;
    start_job(32'h0000_1000);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (bus.master_write && bus.master_address == 32'h1010) begin found = 1; break; end
    end
    fft_done = 1; base_address = 32'h0000_2000;
    @(negedge clk); #1;
    fft_done = 0;
    n_checks++;
    if (!found) $display("FAIL busy_start_setup: word 4 write not seen"); else n_pass++;
    wait_done();
    n_checks++;
    if (n_acc !== N || done_cyc.size() !== 1)
      $display("FAIL busy_start_count: got %0d writes %0d done pulses expected %0d and 1", n_acc, done_cyc.size(), N);
    else n_pass++;
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (i >= acc_addr.size() || acc_addr[i] !== 32'h1000 + 4 * i)
        $display("FAIL busy_start_addr%0d: got %h expected %h", i, i < acc_addr.size() ? acc_addr[i] : 'x, 32'h1000 + 4 * i);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    fill_ramp();
    mode = 0;
    start_job(32'h0000_1000);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (bus.master_write && bus.master_address == 32'h1014) begin found = 1; break; end
    end
    #2 rst = 1;
    #1;
    n_checks++;
    if (!found || bus.master_write !== 1'b0 || xfer_done !== 1'b0 || busy !== 1'b0)
      $display("FAIL mid_reset: found=%b got write=%b done=%b busy=%b expected 1 0 0 0", found, bus.master_write, xfer_done, busy);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (5) @(negedge clk);
    #1;
    n_checks++;
    if (done_cyc.size() !== 0) $display("FAIL mid_no_done: got %0d done pulses expected 0", done_cyc.size()); else n_pass++;
    start_job(32'h0000_3000);
    wait_done();
    n_checks++;
    if (n_acc !== N || acc_addr[0] !== 32'h3000 || acc_data[0] !== ram[0] || acc_addr[N-1] !== 32'h301C)
      $display("FAIL mid_restart: got %0d writes first=%h/%h last=%h expected %0d 00003000/%h 0000301c", n_acc,
               acc_addr.size() > 0 ? acc_addr[0] : 'x, acc_data.size() > 0 ? acc_data[0] : 'x,
               acc_addr.size() >= N ? acc_addr[N-1] : 'x, N, ram[0]);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] b = 32'hFFFF_FFF8;
    fill_ramp();
    mode = 0;
    start_job(b);
    wait_done();
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (i >= acc_addr.size() || acc_addr[i] !== 32'(b + 4 * i))
        $display("FAIL wrap_addr%0d: got %h expected %h", i, i < acc_addr.size() ? acc_addr[i] : 'x, 32'(b + 4 * i));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [31:0] b;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) ram[i] = $urandom;
      b = $urandom;
      mode = 2;
      start_job(b);
      wait_done();
      mode = 0;
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (i >= acc_addr.size() || acc_addr[i] !== 32'(b + 4 * i) || acc_data[i] !== ram[i])
          $display("FAIL rand%0d_word%0d: got addr=%h data=%h expected %h %h", r, i, i < acc_addr.size() ? acc_addr[i] : 'x,
                   i < acc_data.size() ? acc_data[i] : 'x, 32'(b + 4 * i), ram[i]);
        else n_pass++;
      end
      n_checks++;
      if (n_acc !== N || done_cyc.size() !== 1 || done_cyc[0] - t0 !== 3 * N + 1 + n_stall)
        $display("FAIL rand%0d_done: got %0d writes %0d pulses at %0d expected %0d 1 at %0d", r, n_acc, done_cyc.size(),
                 done_cyc.size() > 0 ? done_cyc[0] - t0 : -1, N, 3 * N + 1 + n_stall);
      else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
    clear_mon();
    test_reset();
    test_nominal();
    test_stall();
    test_start_while_busy();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
